// File: rtl/neuron_mac4.sv
// neuron_mac4
//   Four-input fixed-point neuron. Captures four activations, four weights
//   and a bias in IDLE, accumulates the four products serially (one per
//   clock), adds the bias, applies an optional ReLU, saturates to DW bits
//   and offers the result on a valid/ready port. A per-layer counter pulses
//   done when the NUM_NEURONS-th result is taken by the downstream stage.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   clear           synchronous layer restart (keeps y/sat)
//   in_valid/ready  operand handshake (ready only in IDLE)
//   x1..x4, w1..w4  signed activations / weights (Q(DW-FRAC).FRAC)
//   bias            signed bias, same format as x
//   out_valid/ready result handshake
//   y, sat          result and clip flag, valid with out_valid
//   done            one-cycle pulse after the last neuron of a layer
//   busy            block is not idle

module neuron_mac4 #(
    parameter int DW          = 32,
    parameter int FRAC        = 16,
    parameter int NUM_NEURONS = 4,
    parameter int ACT_RELU    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] x1,
    input  logic signed [DW-1:0] x2,
    input  logic signed [DW-1:0] x3,
    input  logic signed [DW-1:0] x4,
    input  logic signed [DW-1:0] w1,
    input  logic signed [DW-1:0] w2,
    input  logic signed [DW-1:0] w3,
    input  logic signed [DW-1:0] w4,
    input  logic signed [DW-1:0] bias,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic        [DW-1:0] y,
    output logic                 sat,
    output logic                 done,
    output logic                 busy
);

    // Accumulator is wide enough that four shifted products plus the bias
    // can never wrap, so saturation only has to look at the final sum.
    localparam int AW = DW + FRAC + 2;
    localparam int PW = 2 * DW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_BIAS,
        S_ACT,
        S_OUT
    } state_t;

    state_t                r_state;
    logic signed [DW-1:0]  r_x [4];
    logic signed [DW-1:0]  r_w [4];
    logic signed [DW-1:0]  r_bias;
    logic signed [AW-1:0]  r_acc;
    logic        [1:0]     r_idx;
    logic        [7:0]     r_count;
    logic                  r_outValid;
    logic        [DW-1:0]  r_y;
    logic                  r_sat;
    logic                  r_done;

    logic signed [PW-1:0]  w_prod;
    logic signed [AW-1:0]  w_term;
    logic signed [AW-1:0]  w_relu;
    logic                  w_fits;
    logic        [DW-1:0]  w_satVal;

    // Full-precision product of the current operand pair, then the
    // arithmetic shift back to the operand Q format (floor rounding).
    assign w_prod = PW'(r_x[r_idx]) * PW'(r_w[r_idx]);
    assign w_term = AW'(w_prod >>> FRAC);

    // Activation and range check on the finished accumulator. The value fits
    // in DW bits exactly when all bits from DW-1 upward agree with the sign.
    assign w_relu   = ((ACT_RELU != 0) && r_acc[AW-1]) ? '0 : r_acc;
    assign w_fits   = (&w_relu[AW-1:DW-1]) | ~(|w_relu[AW-1:DW-1]);
    assign w_satVal = w_relu[AW-1] ? {1'b1, {(DW-1){1'b0}}}
                                   : {1'b0, {(DW-1){1'b1}}};

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign out_valid = r_outValid;
    assign y         = r_y;
    assign sat       = r_sat;
    // Masked so a registered pulse can never be seen during a restart.
    assign done      = r_done & ~rst & ~clear;

    // Main controller and datapath. clear behaves like rst except that the
    // last result (y/sat) is left visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_acc      <= '0;
            r_idx      <= '0;
            r_count    <= '0;
            r_outValid <= 1'b0;
            r_y        <= '0;
            r_sat      <= 1'b0;
            r_done     <= 1'b0;
        end else if (clear) begin
            r_state    <= S_IDLE;
            r_acc      <= '0;
            r_idx      <= '0;
            r_count    <= '0;
            r_outValid <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_x[0] <= x1;
                        r_x[1] <= x2;
                        r_x[2] <= x3;
                        r_x[3] <= x4;
                        r_w[0] <= w1;
                        r_w[1] <= w2;
                        r_w[2] <= w3;
                        r_w[3] <= w4;
                        r_bias  <= bias;
                        r_acc   <= '0;
                        r_idx   <= '0;
                        r_state <= S_MUL;
                    end
                end
                S_MUL: begin
                    r_acc <= r_acc + w_term;
                    r_idx <= r_idx + 2'd1;
                    if (r_idx == 2'd3) begin
                        r_state <= S_BIAS;
                    end
                end
                S_BIAS: begin
                    r_acc   <= r_acc + AW'(r_bias);
                    r_state <= S_ACT;
                end
                S_ACT: begin
                    r_y        <= w_fits ? w_relu[DW-1:0] : w_satVal;
                    r_sat      <= ~w_fits;
                    r_outValid <= 1'b1;
                    r_state    <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_outValid <= 1'b0;
                        r_state    <= S_IDLE;
                        if (r_count == 8'(NUM_NEURONS - 1)) begin
                            r_count <= '0;
                            r_done  <= 1'b1;
                        end else begin
                            r_count <= r_count + 8'd1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_mac4.sv
// tb_neuron_mac4
//   Directed bench for neuron_mac4. Two instances share all inputs: one with
//   ReLU enabled, one with identity activation, so every vector checks both
//   activation modes. Expected results are hand-computed Q16.16 values.

module tb_neuron_mac4;

    logic        clk;
    logic        rst;
    logic        clear;
    logic        inValid;
    logic        outReady;
    logic [31:0] xIn [4];
    logic [31:0] wIn [4];
    logic [31:0] biasIn;

    logic        inReady,  inReady0;
    logic        outValid, outValid0;
    logic [31:0] yOut,     yOut0;
    logic        satOut,   satOut0;
    logic        doneOut,  doneOut0;
    logic        busyOut,  busyOut0;

    int nChecks = 0;
    int nBad    = 0;
    int modelCount = 0;

    neuron_mac4 #(.DW(32), .FRAC(16), .NUM_NEURONS(4), .ACT_RELU(1)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(inValid), .in_ready(inReady),
        .x1(xIn[0]), .x2(xIn[1]), .x3(xIn[2]), .x4(xIn[3]),
        .w1(wIn[0]), .w2(wIn[1]), .w3(wIn[2]), .w4(wIn[3]),
        .bias(biasIn),
        .out_valid(outValid), .out_ready(outReady),
        .y(yOut), .sat(satOut), .done(doneOut), .busy(busyOut)
    );

    neuron_mac4 #(.DW(32), .FRAC(16), .NUM_NEURONS(4), .ACT_RELU(0)) dut0 (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(inValid), .in_ready(inReady0),
        .x1(xIn[0]), .x2(xIn[1]), .x3(xIn[2]), .x4(xIn[3]),
        .w1(wIn[0]), .w2(wIn[1]), .w3(wIn[2]), .w4(wIn[3]),
        .bias(biasIn),
        .out_valid(outValid0), .out_ready(outReady),
        .y(yOut0), .sat(satOut0), .done(doneOut0), .busy(busyOut0)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nBad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock and land 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load operand inputs (does not raise in_valid).
    task automatic applyStimulus(input logic [31:0] a1, a2, a3, a4,
                                 input logic [31:0] b1, b2, b3, b4,
                                 input logic [31:0] bb);
        xIn[0] = a1; xIn[1] = a2; xIn[2] = a3; xIn[3] = a4;
        wIn[0] = b1; wIn[1] = b2; wIn[2] = b3; wIn[3] = b4;
        biasIn = bb;
    endtask

    // Hand one operand set to the DUTs and collect the results. With hold>0
    // the downstream stalls for that many cycles while junk in_valid pulses
    // are driven, and in_valid is still high on the transfer edge.
    task automatic runNeuron(input string tag,
                             input logic [31:0] expY,  input logic expSat,
                             input logic [31:0] expY0, input logic expSat0,
                             input int hold);
        int  n;
        logic expDone;
        outReady = (hold == 0);
        checkOutput({tag, "_inReady"}, 64'(inReady), 64'd1);
        inValid = 1'b1;
        tick();
        inValid = 1'b0;
        checkOutput({tag, "_busy"}, 64'(busyOut), 64'd1);
        checkOutput({tag, "_inReadyBusy"}, 64'(inReady), 64'd0);
        n = 0;
        while (!outValid && n < 20) begin
            tick();
            n++;
        end
        checkOutput({tag, "_latency"}, 64'(n), 64'd6);
        checkOutput({tag, "_y"}, 64'(yOut), 64'(expY));
        checkOutput({tag, "_sat"}, 64'(satOut), 64'(expSat));
        checkOutput({tag, "_y0"}, 64'(yOut0), 64'(expY0));
        checkOutput({tag, "_sat0"}, 64'(satOut0), 64'(expSat0));
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                inValid = i[0];
                xIn[0]  = 32'hDEAD_0000;
                tick();
                checkOutput({tag, "_holdValid"}, 64'(outValid), 64'd1);
                checkOutput({tag, "_holdY"}, 64'(yOut), 64'(expY));
                checkOutput({tag, "_holdSat0"}, 64'(satOut0), 64'(expSat0));
                checkOutput({tag, "_holdInReady"}, 64'(inReady), 64'd0);
            end
            inValid  = 1'b1;
            outReady = 1'b1;
        end
        expDone = (modelCount == 3);
        modelCount = (modelCount + 1) % 4;
        tick();
        inValid  = 1'b0;
        outReady = 1'b0;
        checkOutput({tag, "_validDrop"}, 64'(outValid), 64'd0);
        checkOutput({tag, "_idle"}, 64'(inReady), 64'd1);
        checkOutput({tag, "_done"}, 64'(doneOut), 64'(expDone));
        tick();
        checkOutput({tag, "_doneOff"}, 64'(doneOut), 64'd0);
        checkOutput({tag, "_notTaken"}, 64'(busyOut), 64'd0);
    endtask

    task automatic runBasic(input string tag);
        applyStimulus(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000,
                      32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000,
                      32'h0);
        runNeuron(tag, 32'h0004_0000, 1'b0, 32'h0004_0000, 1'b0, 0);
    endtask

    initial begin
        int n;
        int seen;
        rst = 1'b1; clear = 1'b0; inValid = 1'b0; outReady = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        checkOutput("rst_inReady", 64'(inReady), 64'd1);
        checkOutput("rst_outValid", 64'(outValid), 64'd0);
        checkOutput("rst_y", 64'(yOut), 64'd0);
        checkOutput("rst_sat", 64'(satOut), 64'd0);
        checkOutput("rst_done", 64'(doneOut), 64'd0);
        checkOutput("rst_busy", 64'(busyOut), 64'd0);
        rst = 1'b0;
        tick();

        // 1.0*1.0 four times -> 4.0
        runBasic("basic");
        // -1.0 four times + 1.0 bias -> -3.0 (ReLU gives 0)
        applyStimulus(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000,
                      32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000,
                      32'h0001_0000);
        runNeuron("relu", 32'h0, 1'b0, 32'hFFFD_0000, 1'b0, 0);
        // Largest positive operands -> clip high
        applyStimulus(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
                      32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
                      32'h0);
        runNeuron("satPos", 32'h7FFF_FFFF, 1'b1, 32'h7FFF_FFFF, 1'b1, 0);
        // Large negative sum -> clip low (identity) or 0 (ReLU); 4th neuron
        applyStimulus(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
                      32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                      32'h0);
        runNeuron("satNeg", 32'h0, 1'b0, 32'h8000_0000, 1'b1, 0);
        // 1*0.5 + 2*0.25 + 3*(-1) + 4*2 + 0.5 = 6.5, with 10 stall cycles
        applyStimulus(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000,
                      32'h0000_8000, 32'h0000_4000, 32'hFFFF_0000, 32'h0002_0000,
                      32'h0000_8000);
        runNeuron("mixHold", 32'h0006_8000, 1'b0, 32'h0006_8000, 1'b0, 10);
        // (-1 lsb)*0.5 floors to -1 lsb each -> -4 lsb
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                      32'h0000_8000, 32'h0000_8000, 32'h0000_8000, 32'h0000_8000,
                      32'h0);
        runNeuron("trunc", 32'h0, 1'b0, 32'hFFFF_FFFC, 1'b0, 0);
        runBasic("basic7");
        runBasic("basic8");

        // Reset while the third product is being accumulated.
        runBasic("preRst");
        applyStimulus(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000,
                      32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000,
                      32'h0);
        inValid = 1'b1;
        tick();
        inValid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        modelCount = 0;
        checkOutput("midRst_outValid", 64'(outValid), 64'd0);
        checkOutput("midRst_busy", 64'(busyOut), 64'd0);
        checkOutput("midRst_inReady", 64'(inReady), 64'd1);
        checkOutput("midRst_y", 64'(yOut), 64'd0);
        checkOutput("midRst_sat", 64'(satOut0), 64'd0);
        checkOutput("midRst_done", 64'(doneOut), 64'd0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (outValid) seen++;
        end
        checkOutput("midRst_noValid", 64'(seen), 64'd0);

        // Two neurons, then a third whose result is discarded by clear.
        runBasic("preClr1");
        runBasic("preClr2");
        applyStimulus(32'h0002_0000, 32'h0002_0000, 32'h0002_0000, 32'h0002_0000,
                      32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000,
                      32'h0);
        inValid = 1'b1;
        tick();
        inValid = 1'b0;
        n = 0;
        while (!outValid && n < 20) begin
            tick();
            n++;
        end
        checkOutput("clr_latency", 64'(n), 64'd6);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        modelCount = 0;
        checkOutput("clr_outValid", 64'(outValid), 64'd0);
        checkOutput("clr_yKept", 64'(yOut), 64'h0008_0000);
        checkOutput("clr_busy", 64'(busyOut), 64'd0);
        checkOutput("clr_done", 64'(doneOut), 64'd0);
        tick();
        checkOutput("clr_doneLater", 64'(doneOut), 64'd0);
        runBasic("postClr1");
        runBasic("postClr2");
        runBasic("postClr3");
        runBasic("postClr4");

        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

    // Absolute time guard so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] time limit");
    end

endmodule
